// File: rtl/operand_loader.sv
// Operand entry front-end: debounced enter/cancel buttons step A -> B -> opcode capture,
// then hold a/b/sel with op_valid until ack. Optional feature macro: CHAIN_RESULT_EN.
module operand_loader #(
    parameter int N               = 4,
    parameter int SEL_W           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     sw,
    input  logic             enter,
    input  logic             cancel,
    input  logic             ack,
    input  logic [N-1:0]     result,
    output logic [N-1:0]     a_out,
    output logic [N-1:0]     b_out,
    output logic [SEL_W-1:0] sel_out,
    output logic             op_valid,
    output logic [1:0]       state_out
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A     = 2'b00,
        S_B     = 2'b01,
        S_OP    = 2'b10,
        S_ISSUE = 2'b11
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] btn_press;
    logic       enter_press;
    logic       cancel_press;

    assign btn_raw      = {cancel, enter};
    assign enter_press  = btn_press[0];
    assign cancel_press = btn_press[1];

    // Identical synchroniser + debouncer per button; press is a one-cycle pulse on accepted rise.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic             press_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        level_reg <= sync2_reg;
                        press_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign btn_press[gi] = press_reg;
        end
    endgenerate

    // Opcode comes from the low switch bits; any bits beyond the switch bank read as zero.
    logic [SEL_W-1:0] sel_cap;
    generate
        for (gi = 0; gi < SEL_W; gi++) begin : g_sel
            if (gi < N) begin : g_sw
                assign sel_cap[gi] = sw[gi];
            end else begin : g_zero
                assign sel_cap[gi] = 1'b0;
            end
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [N-1:0]     a_reg, a_next;
    logic [N-1:0]     b_reg, b_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic             op_valid_reg, op_valid_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_A;
            a_reg        <= '0;
            b_reg        <= '0;
            sel_reg      <= '0;
            op_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            sel_reg      <= sel_next;
            op_valid_reg <= op_valid_next;
        end
    end

`ifndef CHAIN_RESULT_EN
    logic unused_result;
    assign unused_result = ^result;
`endif

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sel_next   = sel_reg;
        if (cancel_press) begin
            // Cancel outranks enter and a coincident ack; the consumer still sees its transfer.
            state_next = S_A;
            a_next     = '0;
            b_next     = '0;
            sel_next   = '0;
        end else begin
            case (state_reg)
                S_A: begin
                    if (enter_press) begin
                        a_next     = sw;
                        state_next = S_B;
                    end
                end
                S_B: begin
                    if (enter_press) begin
                        b_next     = sw;
                        state_next = S_OP;
                    end
                end
                S_OP: begin
                    if (enter_press) begin
                        sel_next   = sel_cap;
                        state_next = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (op_valid_reg && ack) begin
`ifdef CHAIN_RESULT_EN
                        a_next     = result;
                        state_next = S_B;
`else
                        state_next = S_A;
`endif
                    end
                end
                default: state_next = S_A;
            endcase
        end
        op_valid_next = (state_next == S_ISSUE);
    end

    assign a_out     = a_reg;
    assign b_out     = b_reg;
    assign sel_out   = sel_reg;
    assign op_valid  = op_valid_reg;
    assign state_out = state_reg;

endmodule
